// File: rtl/m_dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a debug/loader port.
// One access per cycle to a single-port synchronous memory. The CPU has
// priority. A starving debug port gets a forced grant. A locked debug burst
// may own the memory for up to STARVE_MAX accesses.
//
// state | meaning
// ------+---------------------------------------------------------------
// S_CPU | CPU priority; debug served when CPU idle or starve limit hit
// S_DBG | debug burst owns the memory; CPU stalled while requesting
module m_dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_ce,
    input  logic              w_c_req,
    input  logic              w_c_we,
    input  logic [ADDR_W-1:0] w_c_addr,
    input  logic [DATA_W-1:0] w_c_wdata,
    output logic              w_c_stall,
    output logic              r_c_rvalid,
    output logic [DATA_W-1:0] w_c_rdata,
    input  logic              w_d_req,
    input  logic              w_d_we,
    input  logic              w_d_lock,
    input  logic [ADDR_W-1:0] w_d_addr,
    input  logic [DATA_W-1:0] w_d_wdata,
    output logic              w_d_gnt,
    output logic              r_d_rvalid,
    output logic [DATA_W-1:0] w_d_rdata,
    output logic [ADDR_W-1:0] w_m_addr,
    output logic              w_m_we,
    output logic [DATA_W-1:0] w_m_wdata,
    input  logic [DATA_W-1:0] w_m_rdata
);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [7:0] starve_cnt, starve_nxt;
    logic [7:0] burst_cnt, burst_nxt;
    logic       rd_vld, rd_vld_nxt;
    logic       owner, owner_nxt;     // 0 = CPU issued the pending read, 1 = debug
    logic       cpu_grant, dbg_grant;
    logic       active;

    // Reset blocks every access so no write can leak out while w_rst is high.
    assign active = w_ce & ~w_rst;

    // State, counters and read-return bookkeeping.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state      <= S_CPU;
            starve_cnt <= 8'd0;
            burst_cnt  <= 8'd0;
            rd_vld     <= 1'b0;
            owner      <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
            rd_vld     <= rd_vld_nxt;
            owner      <= owner_nxt;
        end
    end

    // Arbitration, next-state and counter updates; everything holds when inactive.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        burst_nxt  = burst_cnt;
        rd_vld_nxt = rd_vld;
        owner_nxt  = owner;
        cpu_grant  = 1'b0;
        dbg_grant  = 1'b0;
        if (active) begin
            case (state)
                S_CPU: begin
                    dbg_grant = w_d_req & (~w_c_req | (starve_cnt == CNT_MAX));
                    cpu_grant = w_c_req & ~dbg_grant;
                    if (dbg_grant) begin
                        starve_nxt = 8'd0;
                        if (w_d_lock) begin
                            state_nxt = S_DBG;
                            burst_nxt = 8'd1;
                        end
                    end else if (w_d_req) begin
                        if (starve_cnt != CNT_MAX) starve_nxt = starve_cnt + 8'd1;
                    end else begin
                        starve_nxt = 8'd0;
                    end
                end
                S_DBG: begin
                    dbg_grant  = w_d_req;
                    starve_nxt = 8'd0;
                    if (dbg_grant) burst_nxt = burst_cnt + 8'd1;
                    // Exit after the grant that completes the burst so the CPU
                    // gets the very next cycle.
                    if (~w_d_lock | ~w_d_req | (burst_nxt == CNT_MAX)) state_nxt = S_CPU;
                end
                default: state_nxt = S_CPU;
            endcase
            rd_vld_nxt = (cpu_grant & ~w_c_we) | (dbg_grant & ~w_d_we);
            if (rd_vld_nxt) owner_nxt = dbg_grant;
        end
    end

    assign w_d_gnt    = dbg_grant;
    assign w_c_stall  = w_c_req & ~cpu_grant;

    assign w_m_addr   = dbg_grant ? w_d_addr  : w_c_addr;
    assign w_m_wdata  = dbg_grant ? w_d_wdata : w_c_wdata;
    assign w_m_we     = w_ce & ((dbg_grant & w_d_we) | (cpu_grant & w_c_we));

    // Both ports see the memory data; only the valid strobe is steered.
    assign w_c_rdata  = w_m_rdata;
    assign w_d_rdata  = w_m_rdata;
    assign r_c_rvalid = rd_vld & ~owner;
    assign r_d_rvalid = rd_vld & owner;

endmodule

// File: tb/tb_m_dmem_arbiter.sv
// Bench for m_dmem_arbiter: behavioural memory, rule-level reference model,
// a vector table, directed corner sequences and a random phase.
module tb_m_dmem_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SM = 8;

    logic          w_clk = 1'b0;
    logic          w_rst = 1'b1;
    logic          w_ce = 1'b0;
    logic          w_c_req = 1'b0, w_c_we = 1'b0;
    logic [AW-1:0] w_c_addr = '0;
    logic [DW-1:0] w_c_wdata = '0;
    logic          w_c_stall, r_c_rvalid;
    logic [DW-1:0] w_c_rdata;
    logic          w_d_req = 1'b0, w_d_we = 1'b0, w_d_lock = 1'b0;
    logic [AW-1:0] w_d_addr = '0;
    logic [DW-1:0] w_d_wdata = '0;
    logic          w_d_gnt, r_d_rvalid;
    logic [DW-1:0] w_d_rdata;
    logic [AW-1:0] w_m_addr;
    logic          w_m_we;
    logic [DW-1:0] w_m_wdata;
    logic [DW-1:0] w_m_rdata;

    m_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_ce(w_ce),
        .w_c_req(w_c_req), .w_c_we(w_c_we), .w_c_addr(w_c_addr), .w_c_wdata(w_c_wdata),
        .w_c_stall(w_c_stall), .r_c_rvalid(r_c_rvalid), .w_c_rdata(w_c_rdata),
        .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_lock(w_d_lock),
        .w_d_addr(w_d_addr), .w_d_wdata(w_d_wdata),
        .w_d_gnt(w_d_gnt), .r_d_rvalid(r_d_rvalid), .w_d_rdata(w_d_rdata),
        .w_m_addr(w_m_addr), .w_m_we(w_m_we), .w_m_wdata(w_m_wdata), .w_m_rdata(w_m_rdata)
    );

    always #5 w_clk = ~w_clk;

    // Single-port synchronous memory, read data one cycle after the address.
    logic [DW-1:0] tb_mem [0:4095];
    always @(posedge w_clk) begin
        if (w_m_we) tb_mem[w_m_addr] <= w_m_wdata;
        w_m_rdata <= tb_mem[w_m_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          c_req, c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wd;
        logic          d_req, d_we, d_lock;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wd;
        logic          ce, rst;
    } stim_t;

    function automatic stim_t idle();
        stim_t s;
        s.c_req = 0; s.c_we = 0; s.c_addr = '0; s.c_wd = '0;
        s.d_req = 0; s.d_we = 0; s.d_lock = 0; s.d_addr = '0; s.d_wd = '0;
        s.ce = 1; s.rst = 0;
        return s;
    endfunction

    // Reference model: who owns the memory, how long debug has waited,
    // how many grants the current burst has had, and a shadow memory.
    bit            m_dbg = 0;
    int            m_starve = 0;
    int            m_burst = 0;
    bit            e_rv_c = 0, e_rv_d = 0, e_chk = 0;
    logic [DW-1:0] e_data;
    logic [DW-1:0] ref_mem [0:4095];
    bit            ref_known [0:4095];

    task automatic cyc(input stim_t s, output logic a_dg, output logic a_stall);
        bit act, eg_d, eg_c;
        logic [AW-1:0] ra;
        @(negedge w_clk);
        w_rst = s.rst; w_ce = s.ce;
        w_c_req = s.c_req; w_c_we = s.c_we; w_c_addr = s.c_addr; w_c_wdata = s.c_wd;
        w_d_req = s.d_req; w_d_we = s.d_we; w_d_lock = s.d_lock;
        w_d_addr = s.d_addr; w_d_wdata = s.d_wd;
        #1;
        act = s.ce && !s.rst;
        if (s.rst) begin
            m_dbg = 0; m_starve = 0; m_burst = 0; e_rv_c = 0; e_rv_d = 0;
        end
        eg_d = act && s.d_req && (m_dbg || !s.c_req || m_starve == SM);
        eg_c = act && s.c_req && !m_dbg && !eg_d;
        check("d_gnt", 32'(w_d_gnt), 32'(eg_d));
        check("c_stall", 32'(w_c_stall), 32'(s.c_req && !eg_c));
        check("m_we", 32'(w_m_we), 32'((eg_d && s.d_we) || (eg_c && s.c_we)));
        if (eg_d || eg_c) check("m_addr", 32'(w_m_addr), 32'(eg_d ? s.d_addr : s.c_addr));
        if (s.rst) begin
            check("rst_c_rvalid", 32'(r_c_rvalid), 32'd0);
            check("rst_d_rvalid", 32'(r_d_rvalid), 32'd0);
        end
        a_dg = w_d_gnt;
        a_stall = w_c_stall;
        e_chk = 0;
        if (act) begin
            e_rv_c = eg_c && !s.c_we;
            e_rv_d = eg_d && !s.d_we;
            ra = eg_d ? s.d_addr : s.c_addr;
            e_chk = (e_rv_c || e_rv_d) && ref_known[ra];
            e_data = ref_mem[ra];
            if (eg_d && s.d_we) begin ref_mem[s.d_addr] = s.d_wd; ref_known[s.d_addr] = 1; end
            if (eg_c && s.c_we) begin ref_mem[s.c_addr] = s.c_wd; ref_known[s.c_addr] = 1; end
            if (m_dbg) begin
                if (s.d_req) m_burst++;
                if (!s.d_lock || !s.d_req || m_burst == SM) m_dbg = 0;
                m_starve = 0;
            end else if (eg_d) begin
                m_starve = 0;
                if (s.d_lock) begin m_dbg = 1; m_burst = 1; end
            end else if (s.d_req) begin
                if (m_starve < SM) m_starve++;
            end else begin
                m_starve = 0;
            end
        end
        @(posedge w_clk);
        #1;
        check("c_rvalid", 32'(r_c_rvalid), 32'(e_rv_c));
        check("d_rvalid", 32'(r_d_rvalid), 32'(e_rv_d));
        if (e_chk && e_rv_c) check("c_rdata", w_c_rdata, e_data);
        if (e_chk && e_rv_d) check("d_rdata", w_d_rdata, e_data);
    endtask

    typedef struct {
        logic c_req, c_we, d_req, d_we, ce;
        logic exp_stall, exp_gnt;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        stim_t s;
        vec_t  tbl [8];
        logic  g, st;
        int    gi, n, cyc_n;

        tbl[0] = '{1, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 0, 1, 1, 1, 0, 1};
        tbl[2] = '{1, 0, 1, 0, 1, 0, 0};
        tbl[3] = '{1, 1, 1, 1, 0, 1, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 1, 0, 1, 0, 1};
        tbl[6] = '{1, 1, 0, 0, 1, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 1, 0, 0};

        // Reset with a CPU write pending: nothing may reach the memory.
        s = idle(); s.rst = 1; s.c_req = 1; s.c_we = 1; s.c_addr = 12'h7ff;
        cyc(s, g, st);
        check("rst_m_we", 32'(w_m_we), 32'd0);
        cyc(s, g, st);

        // Vector table of single-cycle arbitration cases.
        for (int i = 0; i < 8; i++) begin
            s = idle();
            s.c_req = tbl[i].c_req; s.c_we = tbl[i].c_we; s.c_addr = AW'(12'h100 + i); s.c_wd = DW'(i);
            s.d_req = tbl[i].d_req; s.d_we = tbl[i].d_we; s.d_addr = AW'(12'h180 + i); s.d_wd = DW'(i + 100);
            s.ce = tbl[i].ce;
            cyc(s, g, st);
            check($sformatf("tbl%0d_stall", i), 32'(st), 32'(tbl[i].exp_stall));
            check($sformatf("tbl%0d_gnt", i), 32'(g), 32'(tbl[i].exp_gnt));
        end

        // Preload 0x010 through debug, then a CPU read returns it next cycle only.
        s = idle(); s.d_req = 1; s.d_we = 1; s.d_addr = 12'h010; s.d_wd = 32'hAA;
        cyc(s, g, st);
        check("preload_gnt", 32'(g), 32'd1);
        s = idle(); s.c_req = 1; s.c_addr = 12'h010;
        cyc(s, g, st);
        check("cpu_rd_stall", 32'(st), 32'd0);
        check("cpu_rd_valid", 32'(r_c_rvalid), 32'd1);
        check("cpu_rd_data", w_c_rdata, 32'hAA);
        s = idle();
        cyc(s, g, st);
        check("cpu_rd_valid_once", 32'(r_c_rvalid), 32'd0);

        // Debug write starved by continuous CPU traffic gets a forced grant.
        gi = -1;
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.c_req = 1; s.c_addr = 12'h030;
            if (gi < 0) begin
                s.d_req = 1; s.d_we = 1; s.d_addr = 12'h020; s.d_wd = 32'h1234;
            end
            cyc(s, g, st);
            if (g && gi < 0) begin
                gi = i;
                check("forced_stall", 32'(st), 32'd1);
            end
        end
        check("forced_cycle", 32'(gi), 32'd8);
        s = idle(); s.c_req = 1; s.c_addr = 12'h020;
        cyc(s, g, st);
        check("forced_rdback", w_c_rdata, 32'h1234);

        // Locked burst of 12 writes with the CPU idle.
        n = 0; cyc_n = 0;
        for (int i = 0; i < 20 && n < 12; i++) begin
            s = idle(); s.d_req = 1; s.d_we = 1; s.d_lock = 1;
            s.d_addr = AW'(12'h200 + n); s.d_wd = DW'(32'h5000 + n);
            cyc(s, g, st);
            if (g) n++;
            cyc_n = i + 1;
        end
        check("burst_writes", 32'(n), 32'd12);
        check("burst_cycles", 32'(cyc_n), 32'd12);
        s = idle(); s.c_req = 1; s.c_addr = 12'h208;
        cyc(s, g, st);
        check("burst_rdback", w_c_rdata, 32'h5008);

        // Burst starting with CPU idle, CPU requesting after: CPU waits the burst out.
        gi = -1;
        for (int i = 0; i < 12; i++) begin
            s = idle(); s.d_req = 1; s.d_we = 1; s.d_lock = 1;
            s.d_addr = AW'(12'h300 + i); s.d_wd = DW'(i);
            if (i > 0) begin s.c_req = 1; s.c_addr = 12'h010; end
            cyc(s, g, st);
            if (i > 0 && !st && gi < 0) gi = i;
        end
        check("burst_cpu_resume", 32'(gi), 32'd8);
        s = idle();
        cyc(s, g, st);

        // Debug read then CPU read: each valid appears once, one cycle later.
        s = idle(); s.d_req = 1; s.d_addr = 12'h010;
        cyc(s, g, st);
        check("drd_d_valid", 32'(r_d_rvalid), 32'd1);
        check("drd_c_valid", 32'(r_c_rvalid), 32'd0);
        check("drd_data", w_d_rdata, 32'hAA);
        s = idle(); s.c_req = 1; s.c_addr = 12'h020;
        cyc(s, g, st);
        check("crd_c_valid", 32'(r_c_rvalid), 32'd1);
        check("crd_d_valid", 32'(r_d_rvalid), 32'd0);
        check("crd_data", w_c_rdata, 32'h1234);
        s = idle();
        cyc(s, g, st);
        check("rd_done_c", 32'(r_c_rvalid), 32'd0);
        check("rd_done_d", 32'(r_d_rvalid), 32'd0);

        // Reset in the third cycle of a burst aborts it.
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.d_req = 1; s.d_we = 1; s.d_lock = 1;
            s.d_addr = AW'(12'h400 + i); s.d_wd = DW'(32'hB0 + i);
            if (i == 2) s.rst = 1;
            if (i == 3) begin s.c_req = 1; s.c_addr = 12'h010; end
            cyc(s, g, st);
            if (i == 2) check("rst_burst_we", 32'(w_m_we), 32'd0);
            if (i == 3) check("rst_cpu_first", 32'(g), 32'd0);
        end
        s = idle();
        cyc(s, g, st);

        // Clock enable low with both requesting: nothing moves, then starvation resumes.
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.c_req = 1; s.c_we = 1; s.c_addr = 12'h500; s.c_wd = DW'(i);
            s.d_req = 1; s.d_we = 1; s.d_addr = 12'h501; s.d_wd = 32'hC0;
            cyc(s, g, st);
        end
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.ce = 0; s.c_req = 1; s.c_we = 1; s.c_addr = 12'h500;
            s.d_req = 1; s.d_we = 1; s.d_addr = 12'h501; s.d_wd = 32'hC0;
            cyc(s, g, st);
            check("ce0_m_we", 32'(w_m_we), 32'd0);
            check("ce0_stall", 32'(st), 32'd1);
        end
        gi = -1;
        for (int i = 0; i < 10 && gi < 0; i++) begin
            s = idle(); s.c_req = 1; s.c_we = 1; s.c_addr = 12'h500; s.c_wd = DW'(i);
            s.d_req = 1; s.d_we = 1; s.d_addr = 12'h501; s.d_wd = 32'hC0;
            cyc(s, g, st);
            if (g) gi = i;
        end
        check("ce0_starve_held", 32'(gi), 32'd5);
        s = idle();
        cyc(s, g, st);

        // Random traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            s.c_req  = 1'($urandom_range(1));
            s.c_we   = 1'($urandom_range(1));
            s.c_addr = AW'($urandom_range(15));
            s.c_wd   = $urandom;
            s.d_req  = 1'($urandom_range(1));
            s.d_we   = 1'($urandom_range(1));
            s.d_lock = ($urandom_range(3) != 0);
            s.d_addr = AW'($urandom_range(15));
            s.d_wd   = $urandom;
            s.ce     = ($urandom_range(7) != 0);
            s.rst    = ($urandom_range(63) == 0);
            cyc(s, g, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/m_dmem_arbiter.md
M_DMEM_ARBITER -- requirements
Module: m_dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word address width of the shared data memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 8, maximum consecutive denied cycles for the debug port, and maximum debug burst length (range 2..255).
REQ-004 w_clk  in  1  single clock; all state on rising edge.
REQ-005 w_rst  in  1  reset, asynchronous, active-high.
REQ-006 w_ce  in  1  clock enable; when 0, all state holds.
REQ-007 w_c_req, w_c_we  in  1  CPU (MEM-stage) access request, write select.
REQ-008 w_c_addr  in  ADDR_W  CPU word address; w_c_wdata  in  DATA_W  CPU store data.
REQ-009 w_c_stall  out  1  combinational; CPU request not serviced this cycle, pipeline must hold.
REQ-010 r_c_rvalid  out  1  registered; CPU read data valid; w_c_rdata  out  DATA_W  read data.
REQ-011 w_d_req, w_d_we, w_d_lock  in  1  debug/loader request, write select, burst-lock.
REQ-012 w_d_addr  in  ADDR_W; w_d_wdata  in  DATA_W  debug address and write data.
REQ-013 w_d_gnt  out  1  combinational; debug access is performed this cycle.
REQ-014 r_d_rvalid  out  1  registered; w_d_rdata  out  DATA_W  debug read data.
REQ-015 w_m_addr  out  ADDR_W, w_m_we  out  1, w_m_wdata  out  DATA_W  to single-port synchronous memory; w_m_rdata  in  DATA_W  (valid one cycle after address).

Function
REQ-016 States: S_CPU (CPU priority) and S_DBG (debug owns the memory); exactly one access per cycle.
REQ-017 S_CPU: CPU granted whenever w_c_req=1; debug granted only when w_c_req=0, or when starve_cnt==STARVE_MAX.
REQ-018 starve_cnt: increments (saturating at STARVE_MAX) each enabled cycle with w_d_req=1 and w_d_gnt=0; clears on any debug grant or when w_d_req=0.
REQ-019 Forced grant (starve_cnt==STARVE_MAX and w_c_req=1): debug granted, w_c_stall=1.
REQ-020 S_CPU -> S_DBG when debug is granted with w_d_lock=1; burst_cnt loads 1.
REQ-021 S_DBG: debug granted every cycle w_d_req=1; CPU stalled whenever w_c_req=1; burst_cnt increments per debug grant.
REQ-022 S_DBG -> S_CPU when w_d_lock=0, or w_d_req=0, or burst_cnt==STARVE_MAX; the following cycle the CPU has absolute priority (starve_cnt forced to 0).
REQ-023 w_c_stall = w_c_req & ~cpu_grant; w_c_stall=0 whenever w_c_req=0.
REQ-024 Memory mux: w_m_addr/w_m_wdata from the granted port; w_m_we = grant & port_we & w_ce; address defaults to CPU port when no grant.
REQ-025 Read latency exactly 1 cycle: a granted read in cycle N gives rvalid=1 for that port in cycle N+1 only; writes never raise rvalid.
REQ-026 Owner register records the read issuer; w_c_rdata and w_d_rdata both equal w_m_rdata; only rvalid is qualified.
REQ-027 Back-to-back write then read of the same address in consecutive cycles returns the newly written value.
REQ-028 w_ce=0: no grant, w_m_we=0, w_c_stall=w_c_req, rvalid registers hold, counters and state hold.
REQ-029 Simultaneous request, no lock, no starvation: CPU wins; debug denied with w_d_gnt=0.

Reset
REQ-030 On w_rst=1, asynchronously: state=S_CPU, starve_cnt=0, burst_cnt=0, r_c_rvalid=0, r_d_rvalid=0, owner=CPU.
REQ-031 Reset mid-burst aborts the burst; no write is issued while w_rst=1 (w_m_we=0).
REQ-032 First edge after deassertion arbitrates as in REQ-017.

Verification
REQ-033 CPU read addr 0x010 (mem=0x0000_00AA), no debug -> w_c_stall=0, r_c_rvalid=1 next cycle, w_c_rdata=0xAA.
REQ-034 CPU req held high 20 cycles, debug write 0x020<=0x1234 pending -> denied 8 cycles, granted cycle 9 with w_c_stall=1, then CPU resumes; read 0x020 returns 0x1234.
REQ-035 Debug lock burst of 12 writes, CPU idle -> 8 writes granted, one cycle returns to S_CPU, remaining 4 complete in a second burst.
REQ-036 Debug read granted (CPU idle) then CPU read next cycle -> r_d_rvalid in cycle 2 only, r_c_rvalid in cycle 3 only.
REQ-037 w_rst pulsed during burst cycle 3 -> state S_CPU, both rvalid 0, no write during reset.
REQ-038 w_ce low 3 cycles with both requests -> no memory writes, starve_cnt unchanged, w_c_stall=1.
